// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for the 5-stage ARM core. It produces the
// forwarding selects for the Execute-stage operand muxes and the stall and
// flush controls for the F/D/E pipeline registers. It keeps its own copy of the
// Memory/Writeback destination register, RegWrite and PCSrc, so Execute only
// exports its E-stage control. Saturating debug counters record the number of
// cycles with stallD=1 and with flushE=1.
//
// Parameters
//   CNT_W         width of the saturating stall/flush counters
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   RA1D, RA2D    Decode-stage source registers
//   RA1E, RA2E    Execute-stage source registers (operand A / operand B)
//   WriteAddrE    Execute-stage destination register
//   RegWriteE     Execute-stage register write (condition already applied)
//   MemtoRegE     Execute-stage instruction is a load
//   PCSrcD        Decode-stage instruction writes the PC (non-branch)
//   PCSrcE        Execute-stage PC write (condition already applied)
//   BranchTakenE  branch resolved taken in Execute
//   forwardAE/BE  operand select: 00 register file, 01 ResultW, 10 ALUResultM
//   stallF        hold the PC register
//   stallD        hold the F/D register
//   flushD        clear the F/D register
//   flushE        clear the D/E register
//   stallCount    cycles with stallD=1, saturating
//   flushCount    cycles with flushE=1, saturating
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WriteAddrE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             BranchTakenE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam logic [3:0] PcReg = 4'd15;

    // Shadow of the Memory and Writeback stage control
    logic [3:0]       write_addr_m_q, write_addr_m_d;
    logic             reg_write_m_q, reg_write_m_d;
    logic             pc_src_m_q, pc_src_m_d;
    logic [3:0]       write_addr_w_q, write_addr_w_d;
    logic             reg_write_w_q, reg_write_w_d;
    logic             pc_src_w_q, pc_src_w_d;

    // Debug counters
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             ldr_stall;
    logic             pc_wr_pend;

    // Youngest writer wins; R15 reads come from PC+8 and are never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra,
        input logic [3:0] wa_m,
        input logic       rw_m,
        input logic [3:0] wa_w,
        input logic       rw_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != PcReg) begin
            if (rw_m && (wa_m == ra)) begin
                sel = 2'b10;
            end else if (rw_w && (wa_w == ra)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    // Hazard detection and output equations
    always_comb begin
        ldr_stall  = MemtoRegE && RegWriteE && (WriteAddrE != PcReg) &&
                     ((WriteAddrE == RA1D) || (WriteAddrE == RA2D));
        pc_wr_pend = PCSrcD || PCSrcE || pc_src_m_q;

        if (reset) begin
            forwardAE = 2'b00;
            forwardBE = 2'b00;
            stallF    = 1'b0;
            stallD    = 1'b0;
            flushD    = 1'b1;
            flushE    = 1'b1;
        end else begin
            forwardAE = fwd_sel(RA1E, write_addr_m_q, reg_write_m_q,
                                write_addr_w_q, reg_write_w_q);
            forwardBE = fwd_sel(RA2E, write_addr_m_q, reg_write_m_q,
                                write_addr_w_q, reg_write_w_q);
            stallD    = ldr_stall;
            stallF    = ldr_stall || pc_wr_pend;
            // With ldr_stall and BranchTakenE together, flushD beats stallD at F/D.
            flushD    = pc_wr_pend || pc_src_w_q || BranchTakenE;
            flushE    = ldr_stall || BranchTakenE;
        end
    end

    // Next state: M and W never stall, so they advance every cycle.
    // flushE clears the D/E register, i.e. the instruction that would enter E
    // next cycle; that bubble reaches us through the E-stage inputs then. The
    // instruction currently in E (the load or the taken branch) still proceeds
    // to M with its own control, which keeps load-use forwarding working.
    always_comb begin
        write_addr_m_d = WriteAddrE;
        reg_write_m_d  = RegWriteE;
        pc_src_m_d     = PCSrcE;
        write_addr_w_d = write_addr_m_q;
        reg_write_w_d  = reg_write_m_q;
        pc_src_w_d     = pc_src_m_q;

        stall_cnt_d = stall_cnt_q;
        if (stallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (flushE && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_addr_m_q <= 4'd0;
            reg_write_m_q  <= 1'b0;
            pc_src_m_q     <= 1'b0;
            write_addr_w_q <= 4'd0;
            reg_write_w_q  <= 1'b0;
            pc_src_w_q     <= 1'b0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            write_addr_m_q <= write_addr_m_d;
            reg_write_m_q  <= reg_write_m_d;
            pc_src_m_q     <= pc_src_m_d;
            write_addr_w_q <= write_addr_w_d;
            reg_write_w_q  <= reg_write_w_d;
            pc_src_w_q     <= pc_src_w_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;

endmodule
